pixel_stream_packer: RTL and testbench

- Downstream consumer of the ADC sample write port (fifo_wr_en / fifo_wr_data) of the panel controller.
- Buffers 14-bit pixel samples in an internal FIFO and returns fifo_full / fifo_empty status upstream.
- Emits a valid/ready pixel stream framed with start-of-frame, start-of-line and end-of-line markers, using a line/row geometry latched at frame start.

---
 rtl/pixel_stream_packer.sv | 171 +++++++++++++++++
 tb/tb_pixel_stream_packer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_packer.sv
// rtl/pixel_stream_packer.sv - sample FIFO feeding a framed valid/ready pixel stream
// Geometry is latched at frame start; markers derive from the col/row counters.
module pixel_stream_packer #(
   parameter int DATA_W = 14,
   parameter int DEPTH  = 16,
   parameter int OUT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       fifo_full,
   output logic                       fifo_empty,
   output logic [$clog2(DEPTH):0]     fifo_level,
   input  logic [11:0]                cfg_cols_m1,
   input  logic [11:0]                cfg_rows_m1,
   input  logic                       frame_start,
   input  logic                       abort,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [OUT_W-1:0]           m_data,
   output logic                       m_sof,
   output logic                       m_sol,
   output logic                       m_eol,
   output logic                       stream_busy,
   output logic                       frame_done,
   output logic                       overflow,
   output logic                       overflow_sticky
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef enum logic [0:0] {IDLE, STREAM} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       level_q, level_d;
   logic                full_q, full_d, empty_q, empty_d;
   logic [11:0]         cols_q, cols_d, rows_q, rows_d;
   logic [11:0]         col_q, col_d, row_q, row_d;
   logic                frame_done_q, frame_done_d;
   logic                overflow_q, overflow_d;
   logic                sticky_q, sticky_d;

   logic                wr_fire, pop, last_beat;

   assign m_valid   = (state_q == STREAM) && !empty_q;
   assign wr_fire   = wr_en && !full_q && !abort;
   assign pop       = m_valid && m_ready && !abort;
   assign last_beat = (col_q == cols_q) && (row_q == rows_q);

   // Head of RAM is shown directly; it cannot change under a stall since writes never target a non-empty head.
   assign m_data = m_valid ? OUT_W'(mem_q[rd_ptr_q]) : '0;
   assign m_sof  = m_valid && (col_q == 12'd0) && (row_q == 12'd0);
   assign m_sol  = m_valid && (col_q == 12'd0);
   assign m_eol  = m_valid && (col_q == cols_q);

   assign fifo_full       = full_q;
   assign fifo_empty      = empty_q;
   assign fifo_level      = level_q;
   assign stream_busy     = (state_q == STREAM);
   assign frame_done      = frame_done_q;
   assign overflow        = overflow_q;
   assign overflow_sticky = sticky_q;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      overflow_d   = 1'b0;
      sticky_d     = sticky_q;
      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         sticky_d = 1'b0;
      end else begin
         if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + LW'(wr_fire) - LW'(pop);
         if (wr_en && full_q) begin
            overflow_d = 1'b1;
            sticky_d   = 1'b1;
         end
      end
      full_d  = (level_d == FULL_LVL);
      empty_d = (level_d == '0);
   end

   always_comb begin
      state_d      = state_q;
      cols_d       = cols_q;
      rows_d       = rows_q;
      col_d        = col_q;
      row_d        = row_q;
      frame_done_d = 1'b0;
      if (abort) begin
         state_d = IDLE;
         col_d   = '0;
         row_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (frame_start) begin
                  cols_d  = cfg_cols_m1;
                  rows_d  = cfg_rows_m1;
                  col_d   = '0;
                  row_d   = '0;
                  state_d = STREAM;
               end
            end
            STREAM: begin
               if (pop) begin
                  if (last_beat) begin
                     col_d        = '0;
                     row_d        = '0;
                     state_d      = IDLE;
                     frame_done_d = 1'b1;
                  end else if (col_q == cols_q) begin
                     col_d = '0;
                     row_d = row_q + 12'd1;
                  end else begin
                     col_d = col_q + 12'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         cols_q       <= '0;
         rows_q       <= '0;
         col_q        <= '0;
         row_q        <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         sticky_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         cols_q       <= cols_d;
         rows_q       <= rows_d;
         col_q        <= col_d;
         row_q        <= row_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         sticky_q     <= sticky_d;
      end
   end

endmodule

// File: tb/tb_pixel_stream_packer.sv
// tb/tb_pixel_stream_packer.sv - directed vectors for pixel_stream_packer
module tb_pixel_stream_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [13:0] wr_data = '0;
   logic        fifo_full, fifo_empty;
   logic [4:0]  fifo_level;
   logic [11:0] cfg_cols_m1 = '0;
   logic [11:0] cfg_rows_m1 = '0;
   logic        frame_start = 1'b0;
   logic        abort = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [15:0] m_data;
   logic        m_sof, m_sol, m_eol;
   logic        stream_busy, frame_done, overflow, overflow_sticky;

   int n_vec = 0;
   int n_bad = 0;

   pixel_stream_packer dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
      .cfg_cols_m1(cfg_cols_m1), .cfg_rows_m1(cfg_rows_m1),
      .frame_start(frame_start), .abort(abort),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_sof(m_sof), .m_sol(m_sol), .m_eol(m_eol),
      .stream_busy(stream_busy), .frame_done(frame_done),
      .overflow(overflow), .overflow_sticky(overflow_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [13:0] v);
      wr_en   = 1'b1;
      wr_data = v;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic chk_beat(input string tag, input logic [15:0] d,
                           input logic sof, input logic sol, input logic eol);
      chk({tag, ".valid"}, 32'(m_valid), 32'd1);
      chk({tag, ".data"},  32'(m_data),  32'(d));
      chk({tag, ".sof"},   32'(m_sof),   32'(sof));
      chk({tag, ".sol"},   32'(m_sol),   32'(sol));
      chk({tag, ".eol"},   32'(m_eol),   32'(eol));
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk("rst.empty", 32'(fifo_empty), 32'd1);
      chk("rst.full",  32'(fifo_full),  32'd0);
      chk("rst.level", 32'(fifo_level), 32'd0);
      chk("rst.valid", 32'(m_valid),    32'd0);
      chk("rst.data",  32'(m_data),     32'd0);
      chk("rst.busy",  32'(stream_busy), 32'd0);
      chk("rst.done",  32'(frame_done), 32'd0);
      chk("rst.ovf",   32'(overflow),   32'd0);
      chk("rst.stky",  32'(overflow_sticky), 32'd0);

      // 2x2 frame of 1..4
      for (int i = 1; i <= 4; i++) push(14'(i));
      chk("f1.level", 32'(fifo_level), 32'd4);
      chk("f1.idle_valid", 32'(m_valid), 32'd0);
      cfg_cols_m1 = 12'd1;
      cfg_rows_m1 = 12'd1;
      frame_start = 1'b1;
      m_ready     = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("f1.busy", 32'(stream_busy), 32'd1);
      for (int b = 0; b < 4; b++) begin
         chk_beat($sformatf("f1.b%0d", b), 16'(b + 1), b == 0, (b % 2) == 0, (b % 2) == 1);
         chk("f1.nodone", 32'(frame_done), 32'd0);
         tick();
      end
      chk("f1.done",  32'(frame_done),  32'd1);
      chk("f1.busy0", 32'(stream_busy), 32'd0);
      chk("f1.valid0", 32'(m_valid),    32'd0);
      chk("f1.empty", 32'(fifo_empty),  32'd1);
      m_ready = 1'b0;
      tick();
      chk("f1.done_pulse", 32'(frame_done), 32'd0);

      // fill to full, 17th write dropped
      for (int i = 0; i < 17; i++) begin
         wr_en   = 1'b1;
         wr_data = 14'(16 + i);
         if (i == 16) begin
            chk("ovf.full",  32'(fifo_full), 32'd1);
            chk("ovf.pre",   32'(overflow),  32'd0);
         end
         tick();
      end
      wr_en = 1'b0;
      chk("ovf.pulse", 32'(overflow),   32'd1);
      chk("ovf.level", 32'(fifo_level), 32'd16);
      tick();
      chk("ovf.pulse_end", 32'(overflow), 32'd0);
      chk("ovf.sticky", 32'(overflow_sticky), 32'd1);
      chk("ovf.level2", 32'(fifo_level), 32'd16);

      // 4x4 frame under 1,0,0,1 backpressure
      begin
         automatic logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
         automatic int e = 0;
         cfg_cols_m1 = 12'd3;
         cfg_rows_m1 = 12'd3;
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         for (int c = 0; c < 100 && e < 16; c++) begin
            m_ready = pat[c % 4];
            chk_beat($sformatf("bp.c%0d", c), 16'(16 + e), e == 0, (e % 4) == 0, (e % 4) == 3);
            if (m_ready) e++;
            tick();
         end
         m_ready = 1'b0;
         chk("bp.count", 32'(e), 32'd16);
         chk("bp.done",  32'(frame_done), 32'd1);
         chk("bp.level", 32'(fifo_level), 32'd0);
         chk("bp.full0", 32'(fifo_full),  32'd0);
         chk("bp.sticky", 32'(overflow_sticky), 32'd1);
      end

      // push/pop together at level 8, 1x18 frame
      for (int i = 0; i < 8; i++) push(14'h40 + 14'(i));
      cfg_cols_m1 = 12'd17;
      cfg_rows_m1 = 12'd0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      m_ready     = 1'b1;
      for (int k = 0; k < 10; k++) begin
         wr_en   = 1'b1;
         wr_data = 14'h48 + 14'(k);
         chk($sformatf("pp.level%0d", k), 32'(fifo_level), 32'd8);
         chk($sformatf("pp.data%0d", k),  32'(m_data), 32'h40 + 32'(k));
         tick();
      end
      wr_en = 1'b0;
      chk("pp.level_end", 32'(fifo_level), 32'd8);
      for (int k = 10; k < 18; k++) begin
         chk_beat($sformatf("pp.b%0d", k), 16'h40 + 16'(k), 1'b0, 1'b0, k == 17);
         tick();
      end
      m_ready = 1'b0;
      chk("pp.done",  32'(frame_done), 32'd1);
      chk("pp.empty", 32'(fifo_empty), 32'd1);

      // single-beat frame
      for (int i = 1; i <= 3; i++) push(14'h60 + 14'(i));
      cfg_cols_m1 = 12'd0;
      cfg_rows_m1 = 12'd0;
      frame_start = 1'b1;
      m_ready     = 1'b1;
      tick();
      frame_start = 1'b0;
      chk_beat("one", 16'h61, 1'b1, 1'b1, 1'b1);
      tick();
      chk("one.done",   32'(frame_done), 32'd1);
      chk("one.valid0", 32'(m_valid),    32'd0);
      chk("one.level",  32'(fifo_level), 32'd2);
      m_ready = 1'b0;

      // abort after 3 of 6 beats
      for (int i = 0; i < 6; i++) push(14'h70 + 14'(i));
      cfg_cols_m1 = 12'd2;
      cfg_rows_m1 = 12'd1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk_beat("ab.b0", 16'h62, 1'b1, 1'b1, 1'b0);
      m_ready = 1'b1;
      tick();
      tick();
      tick();
      m_ready = 1'b0;
      chk("ab.level5", 32'(fifo_level), 32'd5);
      chk_beat("ab.b3", 16'h71, 1'b0, 1'b1, 1'b0);
      chk("ab.sticky1", 32'(overflow_sticky), 32'd1);
      abort   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 14'h99;
      tick();
      abort = 1'b0;
      wr_en = 1'b0;
      chk("ab.level0", 32'(fifo_level), 32'd0);
      chk("ab.empty",  32'(fifo_empty), 32'd1);
      chk("ab.busy",   32'(stream_busy), 32'd0);
      chk("ab.sticky0", 32'(overflow_sticky), 32'd0);
      chk("ab.nodone", 32'(frame_done), 32'd0);
      tick();
      chk("ab.nodone2", 32'(frame_done), 32'd0);

      // restart; a frame_start mid-frame must not re-latch geometry
      push(14'h80);
      push(14'h81);
      cfg_cols_m1 = 12'd1;
      cfg_rows_m1 = 12'd0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk_beat("rs.b0", 16'h80, 1'b1, 1'b1, 1'b0);
      m_ready     = 1'b1;
      frame_start = 1'b1;
      cfg_cols_m1 = 12'd5;
      tick();
      frame_start = 1'b0;
      chk_beat("rs.b1", 16'h81, 1'b0, 1'b0, 1'b1);
      tick();
      m_ready = 1'b0;
      chk("rs.done", 32'(frame_done), 32'd1);
      chk("rs.idle", 32'(stream_busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
